tail_sequencer: RTL and testbench



---
 rtl/tail_sequencer_pkg.sv | 31 +++
 rtl/tail_sequencer_step_prescaler.sv | 42 ++++
 rtl/tail_sequencer.sv | 113 +++++++++++
 tb/tb_tail_sequencer.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/tail_sequencer_pkg.sv
// Shared types and lamp constants for the tail-light sequencer.
package tail_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LEFT   = 2'd1,
    RIGHT  = 2'd2,
    HAZARD = 2'd3
  } mode_t;

  localparam int unsigned LC = 0;
  localparam int unsigned LB = 1;
  localparam int unsigned LA = 2;
  localparam int unsigned RA = 3;
  localparam int unsigned RB = 4;
  localparam int unsigned RC = 5;

  // Indexed by phase; left side lights from LA outward, right side from RA outward.
  localparam logic [3:0][2:0] SEQ_L = {3'b111, 3'b110, 3'b100, 3'b000};
  localparam logic [3:0][2:0] SEQ_R = {3'b111, 3'b011, 3'b001, 3'b000};

  localparam logic [5:0] ALL_ON   = 6'b111111;
  localparam logic [5:0] ALL_OFF  = 6'b000000;
  localparam logic [2:0] SIDE_ON  = 3'b111;
  localparam logic [2:0] SIDE_OFF = 3'b000;

  function automatic logic [2:0] brake_side(input logic brake_on);
    return brake_on ? SIDE_ON : SIDE_OFF;
  endfunction

endpackage

// File: rtl/tail_sequencer_step_prescaler.sv
// Step-rate prescaler: one-cycle step pulse every STEP_CYCLES clocks, restartable by clear.
module step_prescaler #(
  parameter int STEP_CYCLES = 12_500_000
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic step
);

  localparam int CW = (STEP_CYCLES > 2) ? $clog2(STEP_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(STEP_CYCLES - 1);

  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;
  logic          at_last_s;

  assign at_last_s = (count_q == LAST);
  assign step      = at_last_s && !clear;

  // Next count: restart on clear, wrap after the last count.
  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (at_last_s) begin
      count_d = '0;
    end else begin
      count_d = count_q + CW'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/tail_sequencer.sv
// Tail-light pattern generator: sequential turn, hazard flash, brake overlay.
// Optional macro TAIL_DUAL_HAZARD_EN: left+right together requests hazard flashing.
module tail_sequencer
  import tail_pkg::*;
#(
  parameter int STEP_CYCLES = 12_500_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       left,
  input  logic       right,
  input  logic       hazard,
  input  logic       brake,
  output logic [5:0] patterns
);

  mode_t       req_s;
  mode_t       mode_q;
  mode_t       mode_d;
  logic [1:0]  phase_q;
  logic [1:0]  phase_d;
  logic [5:0]  patterns_q;
  logic [5:0]  patterns_d;
  logic        mode_chg_s;
  logic        step_s;

  step_prescaler #(.STEP_CYCLES(STEP_CYCLES)) u_prescaler (
    .clk   (clk),
    .reset (reset),
    .clear (mode_chg_s),
    .step  (step_s)
  );

  // Requested mode by priority.
  always_comb begin
    req_s = IDLE;
    if (hazard) begin
      req_s = HAZARD;
    end else if (left && right) begin
`ifdef TAIL_DUAL_HAZARD_EN
      req_s = HAZARD;
`else
      req_s = IDLE;
`endif
    end else if (left) begin
      req_s = LEFT;
    end else if (right) begin
      req_s = RIGHT;
    end else begin
      req_s = IDLE;
    end
  end

  assign mode_chg_s = (req_s != mode_q);

  // Mode/phase next state; a mode change always restarts at phase 0.
  always_comb begin
    mode_d  = mode_q;
    phase_d = phase_q;
    if (mode_chg_s) begin
      mode_d  = req_s;
      phase_d = 2'd0;
    end else if (step_s) begin
      case (mode_q)
        LEFT, RIGHT: phase_d = phase_q + 2'd1;
        HAZARD:      phase_d = {1'b0, ~phase_q[0]};
        default:     phase_d = phase_q;
      endcase
    end else begin
      phase_d = phase_q;
    end
  end

  // Lamp word from current mode, phase and brake.
  always_comb begin
    patterns_d = ALL_OFF;
    case (mode_q)
      IDLE: begin
        patterns_d = brake ? ALL_ON : ALL_OFF;
      end
      LEFT: begin
        patterns_d[LA:LC] = SEQ_L[phase_q];
        patterns_d[RC:RA] = brake_side(brake);
      end
      RIGHT: begin
        patterns_d[RC:RA] = SEQ_R[phase_q];
        patterns_d[LA:LC] = brake_side(brake);
      end
      HAZARD: begin
        patterns_d = phase_q[0] ? ALL_OFF : ALL_ON;
      end
      default: begin
        patterns_d = ALL_OFF;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      mode_q     <= IDLE;
      phase_q    <= 2'd0;
      patterns_q <= ALL_OFF;
    end else begin
      mode_q     <= mode_d;
      phase_q    <= phase_d;
      patterns_q <= patterns_d;
    end
  end

  assign patterns = patterns_q;

endmodule

// File: tb/tb_tail_sequencer.sv
// Directed scoreboard bench for tail_sequencer with STEP_CYCLES = 4.
module tb_tail_sequencer;

  logic       clk;
  logic       reset;
  logic       left;
  logic       right;
  logic       hazard;
  logic       brake;
  logic [5:0] patterns;

  typedef struct {
    string      tag;
    logic [5:0] val;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp;
  int   n_bad;

  tail_sequencer #(.STEP_CYCLES(4)) dut (
    .clk      (clk),
    .reset    (reset),
    .left     (left),
    .right    (right),
    .hazard   (hazard),
    .brake    (brake),
    .patterns (patterns)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic push_exp(input string tag, input int n, input logic [5:0] val);
    for (int i = 0; i < n; i++) begin
      exp_t e;
      e.tag = tag;
      e.val = val;
      sb_q.push_back(e);
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      exp_t e;
      @(posedge clk);
      @(negedge clk);
      n_cmp++;
      if (sb_q.size() == 0) begin
        n_bad++;
        $error("FAIL scoreboard_empty: observed %b required an expectation", patterns);
      end else begin
        e = sb_q.pop_front();
        assert (patterns === e.val) else begin
          n_bad++;
          $error("FAIL %s: observed %b expected %b", e.tag, patterns, e.val);
        end
      end
    end
  endtask

  task automatic idle_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic settle();
    reset  = 1'b0;
    left   = 1'b0;
    right  = 1'b0;
    hazard = 1'b0;
    brake  = 1'b0;
    idle_ticks(2);
  endtask

  initial begin
    n_cmp  = 0;
    n_bad  = 0;
    reset  = 1'b1;
    left   = 1'b1;
    right  = 1'b0;
    hazard = 1'b0;
    brake  = 1'b1;

    // Reset overrides left and brake.
    push_exp("reset_hold", 3, 6'b000000);
    run(3);

    // Release: 2-clk latency then the left sequence, 4 clk per value.
    reset = 1'b0;
    brake = 1'b0;
    push_exp("left_p0",  5, 6'b000000);
    push_exp("left_p1",  4, 6'b000100);
    push_exp("left_p2",  4, 6'b000110);
    push_exp("left_p3",  4, 6'b000111);
    push_exp("left_wrap", 4, 6'b000000);
    run(21);

    // Right with brake, then brake drop.
    settle();
    right = 1'b1;
    brake = 1'b1;
    push_exp("right_brk_lat", 1, 6'b111111);
    push_exp("right_brk_p0",  4, 6'b000111);
    push_exp("right_brk_p1",  4, 6'b001111);
    push_exp("right_brk_p2",  4, 6'b011111);
    push_exp("right_brk_p3",  2, 6'b111111);
    run(15);
    brake = 1'b0;
    push_exp("right_nobrk_p3", 2, 6'b111000);
    push_exp("right_nobrk_p0", 1, 6'b000000);
    run(3);

    // Hazard ignores brake; release with brake held.
    settle();
    hazard = 1'b1;
    brake  = 1'b1;
    push_exp("haz_on0",  5, 6'b111111);
    push_exp("haz_off0", 4, 6'b000000);
    push_exp("haz_on1",  4, 6'b111111);
    run(13);
    hazard = 1'b0;
    push_exp("haz_rel_lat", 1, 6'b000000);
    push_exp("haz_rel_brk", 2, 6'b111111);
    run(3);

    // Mid-sequence switch from left to right restarts the prescaler.
    settle();
    left = 1'b1;
    push_exp("mid_left_p0", 5, 6'b000000);
    push_exp("mid_left_p1", 4, 6'b000100);
    push_exp("mid_left_p2", 2, 6'b000110);
    run(11);
    left  = 1'b0;
    right = 1'b1;
    push_exp("mid_sw_lat",  1, 6'b000110);
    push_exp("mid_right_p0", 4, 6'b000000);
    push_exp("mid_right_p1", 1, 6'b001000);
    run(6);

    // Reset mid-sequence overrides the active request.
    reset = 1'b1;
    push_exp("reset_mid", 2, 6'b000000);
    run(2);

    // Dual request.
    settle();
    left  = 1'b1;
    right = 1'b1;
`ifdef TAIL_DUAL_HAZARD_EN
    push_exp("dual_lat", 1, 6'b000000);
    push_exp("dual_on",  4, 6'b111111);
    push_exp("dual_off", 4, 6'b000000);
`else
    push_exp("dual_idle", 9, 6'b000000);
`endif
    run(9);

    n_cmp++;
    assert (sb_q.size() == 0) else begin
      n_bad++;
      $error("FAIL scoreboard_left: observed %0d pending expected 0", sb_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
